fft_mag_store: RTL and testbench

Spectrum capture stage between the FFT core and the modulation detector. It converts one frame of complex FFT output into 16-bit unsigned magnitudes and stores the low `NUM_BINS` bins in an internal RAM. After the frame is stored it raises `mag_done`, which drives the detector's `en` rising-edge trigger. The detector then reads magnitudes back through a synchronous read port.

---
 rtl/fft_mag_store.sv | 181 ++++++++++++++++++
 tb/tb_fft_mag_store.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_mag_store.sv
// Spectrum capture stage: converts one FFT frame to alpha-max-beta-min magnitudes,
// stores the low NUM_BINS bins in a RAM and tracks the peak bin for the detector.
module fft_mag_store #(
    parameter int FFT_LEN  = 1024,
    parameter int NUM_BINS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        arm,
    input  logic [15:0] fft_re,
    input  logic [15:0] fft_im,
    input  logic        fft_valid,
    input  logic        fft_last,
    input  logic [7:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic        mag_done,
    output logic        frame_err,
    output logic [15:0] peak_mag,
    output logic [7:0]  peak_bin
);

    // state   | meaning
    // IDLE    | after reset, waiting for arm
    // ALIGN   | discarding samples until a frame boundary (valid & last)
    // CAPTURE | counting bins and feeding the magnitude pipeline
    // FLUSH   | two cycles to drain the pipeline into the RAM
    // DONE    | frame stored, RAM and peak frozen, mag_done high
    typedef enum logic [2:0] {IDLE, ALIGN, CAPTURE, FLUSH, DONE} state_t;

    localparam int CW = $clog2(FFT_LEN);
    localparam logic [CW-1:0] LAST_BIN = CW'(FFT_LEN - 1);
    localparam logic [CW-1:0] NB       = CW'(NUM_BINS);

    function automatic logic [15:0] abs16(input logic [15:0] v);
        return v[15] ? (~v + 16'd1) : v;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          flush_cnt_q, flush_cnt_d;
    logic          s1_vld_q, s1_vld_d;
    logic [15:0]   s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [7:0]    s1_bin_q, s1_bin_d;
    logic          s2_vld_q, s2_vld_d;
    logic [15:0]   s2_mag_q, s2_mag_d;
    logic [7:0]    s2_bin_q, s2_bin_d;
    logic          mag_done_q, mag_done_d;
    logic          frame_err_q, frame_err_d;
    logic [15:0]   peak_mag_q, peak_mag_d;
    logic [7:0]    peak_bin_q, peak_bin_d;
    logic [15:0]   rd_data_q, rd_data_d;

    logic [15:0] mem [NUM_BINS];
    logic        abort, accept, eof, wr_en;
    logic [15:0] mx, mn;

    always_comb begin
        abort  = arm && (state_q != IDLE);
        accept = (state_q == CAPTURE) && fft_valid && !arm;
        eof    = accept && (fft_last || (cnt_q == LAST_BIN));
        wr_en  = s2_vld_q && !abort;

        mx = (s1_a_q >= s1_b_q) ? s1_a_q : s1_b_q;
        mn = (s1_a_q >= s1_b_q) ? s1_b_q : s1_a_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        flush_cnt_d = flush_cnt_q;
        mag_done_d  = mag_done_q;
        frame_err_d = frame_err_q;
        peak_mag_d  = peak_mag_q;
        peak_bin_d  = peak_bin_q;
        rd_data_d   = mem[rd_addr];

        // Only bins that will land in the RAM are carried down the pipeline.
        s1_vld_d = accept && (cnt_q < NB);
        s1_a_d   = abs16(fft_re);
        s1_b_d   = abs16(fft_im);
        s1_bin_d = cnt_q[7:0];
        s2_vld_d = s1_vld_q;
        s2_mag_d = mx + {2'b00, mn[15:2]} + {3'b000, mn[15:3]};
        s2_bin_d = s1_bin_q;

        if (s2_vld_q && (s2_bin_q != 8'd0) && (s2_mag_q > peak_mag_q)) begin
            peak_mag_d = s2_mag_q;
            peak_bin_d = s2_bin_q;
        end

        case (state_q)
            IDLE: begin
                if (arm) state_d = ALIGN;
            end
            ALIGN: begin
                if (fft_valid && fft_last) begin
                    state_d    = CAPTURE;
                    cnt_d      = '0;
                    peak_mag_d = '0;
                    peak_bin_d = '0;
                end
            end
            CAPTURE: begin
                if (accept) cnt_d = cnt_q + 1'b1;
                if (eof) begin
                    state_d     = FLUSH;
                    flush_cnt_d = 1'b0;
                    frame_err_d = !(fft_last && (cnt_q == LAST_BIN));
                end
            end
            FLUSH: begin
                if (flush_cnt_q) begin
                    state_d    = DONE;
                    mag_done_d = 1'b1;
                end else begin
                    flush_cnt_d = 1'b1;
                end
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // A boundary seen in the same cycle as arm is used as the alignment point.
        if (abort) begin
            s1_vld_d    = 1'b0;
            s2_vld_d    = 1'b0;
            mag_done_d  = 1'b0;
            flush_cnt_d = 1'b0;
            peak_mag_d  = '0;
            peak_bin_d  = '0;
            cnt_d       = '0;
            state_d     = (fft_valid && fft_last) ? CAPTURE : ALIGN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            flush_cnt_q <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_bin_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_mag_q    <= '0;
            s2_bin_q    <= '0;
            mag_done_q  <= 1'b0;
            frame_err_q <= 1'b0;
            peak_mag_q  <= '0;
            peak_bin_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_cnt_q <= flush_cnt_d;
            s1_vld_q    <= s1_vld_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_bin_q    <= s1_bin_d;
            s2_vld_q    <= s2_vld_d;
            s2_mag_q    <= s2_mag_d;
            s2_bin_q    <= s2_bin_d;
            mag_done_q  <= mag_done_d;
            frame_err_q <= frame_err_d;
            peak_mag_q  <= peak_mag_d;
            peak_bin_q  <= peak_bin_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Magnitude RAM is deliberately not reset; stale data survives rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) mem[s2_bin_q] <= s2_mag_q;
    end

    assign rd_data   = rd_data_q;
    assign mag_done  = mag_done_q;
    assign frame_err = frame_err_q;
    assign peak_mag  = peak_mag_q;
    assign peak_bin  = peak_bin_q;

endmodule

// File: tb/tb_fft_mag_store.sv
// Bench for fft_mag_store: random and directed frames compared against a
// frame-level magnitude/peak model held in plain arrays.
module tb_fft_mag_store;

    logic        clk, rst_n, arm, fft_valid, fft_last;
    logic [15:0] fft_re, fft_im, rd_data, peak_mag;
    logic [7:0]  rd_addr, peak_bin;
    logic        mag_done, frame_err;

    int n_total = 0;
    int n_bad   = 0;
    int fr_re [1024];
    int fr_im [1024];
    int ref_mem [256];
    int ref_pk, ref_pb;
    logic [15:0] rv;

    fft_mag_store dut (
        .clk(clk), .rst_n(rst_n), .arm(arm), .fft_re(fft_re), .fft_im(fft_im),
        .fft_valid(fft_valid), .fft_last(fft_last), .rd_addr(rd_addr),
        .rd_data(rd_data), .mag_done(mag_done), .frame_err(frame_err),
        .peak_mag(peak_mag), .peak_bin(peak_bin)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input int exp);
        n_total++;
        if (got !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_mag(input int re, input int im);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        return mx + mn / 4 + mn / 8;
    endfunction

    task automatic model_frame();
        for (int k = 0; k < 256; k++) ref_mem[k] = ref_mag(fr_re[k], fr_im[k]);
        ref_pk = 0;
        ref_pb = 0;
        for (int k = 1; k < 256; k++)
            if (ref_mem[k] > ref_pk) begin
                ref_pk = ref_mem[k];
                ref_pb = k;
            end
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 1024; k++) begin fr_re[k] = 0; fr_im[k] = 0; end
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 1024; k++) begin fr_re[k] = k; fr_im[k] = 0; end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 1024; k++) begin
            fr_re[k] = int'($urandom_range(0, 65535)) - 32768;
            fr_im[k] = int'($urandom_range(0, 65535)) - 32768;
        end
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    // Junk samples ending with last: the alignment boundary.
    task automatic send_align(input int n);
        for (int i = 0; i < n; i++) begin
            fft_valid = 1'b1;
            fft_re    = 16'($urandom);
            fft_im    = 16'($urandom);
            fft_last  = (i == n - 1);
            tick();
        end
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input int last_idx, input int gap_pct, input int arm_at);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < 4 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
                fft_valid = 1'b0;
                fft_last  = 1'b1;
                tick();
            end
            fft_valid = 1'b1;
            fft_re    = 16'(fr_re[i]);
            fft_im    = 16'(fr_im[i]);
            fft_last  = (i == last_idx);
            arm       = (i == arm_at);
            tick();
            arm = 1'b0;
        end
        fft_valid = 1'b0;
        fft_last  = 1'b0;
    endtask

    // Called right after the edge that accepted the final sample.
    task automatic check_done(input string tag);
        chk({tag, "_done_c1"}, mag_done, 0);
        tick();
        chk({tag, "_done_c2"}, mag_done, 0);
        tick();
        chk({tag, "_done_c3"}, mag_done, 1);
    endtask

    task automatic rd(input int addr, output logic [15:0] data);
        rd_addr = 8'(addr);
        tick();
        data = rd_data;
    endtask

    task automatic check_ram(input string tag);
        for (int k = 0; k < 256; k++) begin
            rd(k, rv);
            chk($sformatf("%s_ram%0d", tag, k), rv, ref_mem[k]);
        end
    endtask

    task automatic check_peak(input string tag);
        chk({tag, "_peak_mag"}, peak_mag, ref_pk);
        chk({tag, "_peak_bin"}, peak_bin, ref_pb);
    endtask

    initial begin
        rst_n = 1'b0; arm = 1'b0; fft_valid = 1'b0; fft_last = 1'b0;
        fft_re = '0; fft_im = '0; rd_addr = '0;
        repeat (3) tick();
        chk("rst_mag_done", mag_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_bin", peak_bin, 0);
        rst_n = 1'b1;
        tick();

        // Ramp frame after a partial frame used for alignment
        pulse_arm();
        send_align(10);
        fill_ramp();
        model_frame();
        send_frame(1024, 1023, 0, -1);
        check_done("ramp");
        chk("ramp_frame_err", frame_err, 0);
        check_ram("ramp");
        check_peak("ramp");

        // Full-scale negative bin
        pulse_arm();
        chk("rearm_clears_done", mag_done, 0);
        send_align(3);
        fill_zero();
        fr_re[100] = -32768;
        fr_im[100] = -32768;
        send_frame(1024, 1023, 0, -1);
        check_done("ext");
        rd(100, rv);
        chk("ext_addr100", rv, 45056);
        chk("ext_peak_mag", peak_mag, 45056);
        chk("ext_peak_bin", peak_bin, 100);

        // Tie between bins 99 and 101
        pulse_arm();
        send_align(2);
        fill_zero();
        fr_re[99] = 3000;  fr_im[99] = 4000;
        fr_re[101] = 3000; fr_im[101] = 4000;
        send_frame(1024, 1023, 0, -1);
        check_done("tie");
        rd(99, rv);
        chk("tie_addr99", rv, 5125);
        rd(101, rv);
        chk("tie_addr101", rv, 5125);
        chk("tie_peak_mag", peak_mag, 5125);
        chk("tie_peak_bin", peak_bin, 99);

        // Short frame: last at bin 700
        pulse_arm();
        send_align(4);
        fill_rand();
        model_frame();
        send_frame(701, 700, 0, -1);
        check_done("short");
        chk("short_frame_err", frame_err, 1);
        check_ram("short");
        check_peak("short");

        // Correct frame clears frame_err
        pulse_arm();
        send_align(4);
        fill_rand();
        model_frame();
        send_frame(1024, 1023, 0, -1);
        check_done("good");
        chk("good_frame_err", frame_err, 0);
        check_ram("good");
        check_peak("good");

        // Abort mid-capture at bin 50, then realign
        pulse_arm();
        send_align(5);
        fill_rand();
        send_frame(51, -1, 0, 50);
        chk("abort_mag_done", mag_done, 0);
        chk("abort_peak_mag", peak_mag, 0);
        send_align(6);
        fill_rand();
        model_frame();
        send_frame(1024, 1023, 0, -1);
        check_done("realign");
        check_ram("realign");
        check_peak("realign");

        // arm together with last: boundary consumed, straight into capture
        pulse_arm();
        send_align(3);
        fill_rand();
        send_frame(30, 29, 0, 29);
        fill_rand();
        model_frame();
        send_frame(1024, 1023, 0, -1);
        check_done("armlast");
        chk("armlast_frame_err", frame_err, 0);
        check_ram("armlast");

        // Ramp with random valid gaps
        pulse_arm();
        send_align(3);
        fill_ramp();
        model_frame();
        send_frame(1024, 1023, 30, -1);
        check_done("gaps");
        check_ram("gaps");
        check_peak("gaps");

        // Frame that never signals last
        pulse_arm();
        send_align(3);
        fill_rand();
        model_frame();
        send_frame(1024, -1, 0, -1);
        check_done("nolast");
        chk("nolast_frame_err", frame_err, 1);
        check_ram("nolast");

        // Async reset mid-capture
        pulse_arm();
        send_align(3);
        fill_rand();
        send_frame(100, -1, 0, -1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mag_done", mag_done, 0);
        chk("arst_frame_err", frame_err, 0);
        chk("arst_peak_mag", peak_mag, 0);
        chk("arst_peak_bin", peak_bin, 0);
        chk("arst_rd_data", rd_data, 0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
